cordic_rr_sched: RTL and testbench
==================================

# cordic_rr_sched

Round-robin scheduler that shares one pipelined CORDIC core among NUM_REQ requesters. It accepts operand bundles over per-requester valid/ready handshakes and issues at most one operation per cycle to the core. It tracks the owner of every in-flight operation in an in-order tag FIFO and returns each result to its owner. It sits between the algorithm front-ends and the single pipelined CORDIC instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width, signed
- NUM_STAGES, 13, core pipeline latency in cycles, cvalid_in to cvalid_out
- TAG_DEPTH, 16, tag FIFO depth; must be ≥ NUM_STAGES + 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  operand bundle valid, one bit per requester
- req_ready  out  NUM_REQ  grant/accept, one bit per requester
- req_x, req_y, req_z  in  NUM_REQ×WIDTH  signed operands, packed, requester i at [i*WIDTH +: WIDTH]
- req_mode  in  NUM_REQ  0 = rotation, 1 = vectoring
- resp_valid  out  NUM_REQ  one-hot result strobe
- resp_cos, resp_sin, resp_tan  out  WIDTH  result buses, shared across requesters, qualified by resp_valid
- cx, cy, cz  out  WIDTH  core operands
- cmode  out  1  core mode
- cvalid_in  out  1  core issue strobe
- ccos, csin, ctan  in  WIDTH  core results
- cvalid_out  in  1  core result strobe
- busy  out  1  tag FIFO non-empty
- err  out  1  sticky: cvalid_out seen while tag FIFO empty

## Operation
- Arbitration: round-robin over req_valid. The pointer rr_ptr (clog2(NUM_REQ) bits) marks the highest-priority requester. The search runs rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- Grant gating: no grant when the tag FIFO count ≥ TAG_DEPTH−1. There is no same-cycle pop bypass.
- req_ready is combinational and one-hot or zero; req_ready[i] is asserted only if req_valid[i] is high. The handshake completes on req_valid[i] & req_ready[i] at a rising edge.
- On a handshake with requester g:
  - Operands and mode are registered into cx/cy/cz/cmode.
  - cvalid_in is set to 1 for exactly one cycle.
  - Tag g is pushed into the FIFO.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- With no handshake: cvalid_in goes to 0, cx/cy/cz/cmode hold their values, rr_ptr holds.
- On cvalid_out:
  - Pop tag t.
  - Register ccos/csin/ctan onto resp_* and set resp_valid = 1<<t for one cycle.
  - Responses have no backpressure; requesters must sink them.
- If cvalid_out arrives with the FIFO empty: set err=1, keep resp_valid=0, and do not change the FIFO. err clears only on reset.
- Simultaneous push and pop: count is unchanged and both take effect.
- Results return in issue order, because the core is in-order.

## Timing
- Reset (async assert, sync release of state): req_ready=0 during reset. resp_valid=0, resp_*=0, cx/cy/cz=0, cmode=0, cvalid_in=0, busy=0, err=0, rr_ptr=0, FIFO empty.
- Issue latency: handshake edge N → cvalid_in high in cycle N+1.
- Result latency: resp_valid asserts one cycle after cvalid_out. The end-to-end handshake-to-response time is NUM_STAGES+2 cycles.
- Throughput: one issue per cycle. With all NUM_REQ requesters continuously valid, each is granted once every NUM_REQ cycles.
- Reset mid-operation: all in-flight tags are discarded. Any later cvalid_out from the un-reset core pipeline sets err. The top level resets the core with the same rst_n.
- busy = (count ≠ 0), registered.

## Structure
- Shared package cordic_pkg:
  - WIDTH default
  - mode constants MODE_ROT=1'b0, MODE_VEC=1'b1
  - tag type tag_t sized clog2(NUM_REQ)
- Sub-module cordic_tag_fifo: synchronous FIFO, TAG_DEPTH×tag_t, with push/pop/full/empty/count. It uses a pointer-wrap read/write index and async active-low reset.
- Round-robin logic stays inline in cordic_rr_sched.

## Test plan
- Single request: req 2 valid with x=0x26DD3B6A, y=0, z=0x20000000, mode=0. Required: req_ready[2] same cycle, cvalid_in next cycle with matching cx/cz, resp_valid=4'b0100 exactly 15 cycles after the handshake, resp_* equal to the core output.
- Full contention: all 4 valid for 12 cycles from reset. Required: grant order 0,1,2,3,0,1,2,3,0,1,2,3 and responses in the same order.
- FIFO full: hold cvalid_out low with a stubbed core and all req_valid=1. Required: exactly TAG_DEPTH−1=15 grants, then req_ready=0 until the first cvalid_out pops a tag.
- Simultaneous push/pop: steady stream at full count−1. Required: count stays constant, no lost or duplicated tags, and the resp_valid sequence matches the issue sequence.
- Spurious result: pulse cvalid_out after reset with nothing issued. Required: err=1 next cycle and stays high; resp_valid stays 0.
- Reset mid-flight: issue 5 ops, assert rst_n low for 2 cycles at cycle 6. Required: all outputs at reset values, busy=0, rr_ptr=0 (next grant goes to requester 0 when all are valid).

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_pkg;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 32;

  // Largest supported requester count; tags are sized to cover it so one
  // tag type serves every legal NUM_REQ.
  localparam int MAX_REQ = 8;

  // Core mode encoding.
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Owner tag carried through the in-flight FIFO.
  typedef logic [$clog2(MAX_REQ)-1:0] tag_t;

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order owner-tag FIFO. The head entry is visible combinationally, so a
// result strobe can be routed to its owner on the same edge it is popped.
module cordic_tag_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  tag_t             din,
  input  logic             pop,
  output tag_t             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_idx];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // Read/write indices wrap at DEPTH-1; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= (wr_idx == AW'(DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      if (do_pop)  rd_idx <= (rd_idx == AW'(DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC core between requesters,
// routing each in-order result back to the requester that issued it.
module cordic_rr_sched
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_STAGES = 13,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y,
  input  logic [NUM_REQ*WIDTH-1:0]   req_z,
  input  logic [NUM_REQ-1:0]         req_mode,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic signed [WIDTH-1:0]    resp_cos,
  output logic signed [WIDTH-1:0]    resp_sin,
  output logic signed [WIDTH-1:0]    resp_tan,
  output logic signed [WIDTH-1:0]    cx,
  output logic signed [WIDTH-1:0]    cy,
  output logic signed [WIDTH-1:0]    cz,
  output logic                       cmode,
  output logic                       cvalid_in,
  input  logic signed [WIDTH-1:0]    ccos,
  input  logic signed [WIDTH-1:0]    csin,
  input  logic signed [WIDTH-1:0]    ctan,
  input  logic                       cvalid_out,
  output logic                       busy,
  output logic                       err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  // The tag FIFO must cover every op that can be in the core pipeline.
  if (TAG_DEPTH < NUM_STAGES + 2) begin : g_depth_check
    $error("TAG_DEPTH must be at least NUM_STAGES + 2");
  end

  logic signed [WIDTH-1:0] x_arr [NUM_REQ];
  logic signed [WIDTH-1:0] y_arr [NUM_REQ];
  logic signed [WIDTH-1:0] z_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
    assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
    assign z_arr[gi] = req_z[gi*WIDTH +: WIDTH];
  end

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_ok;
  logic             pop;
  tag_t             head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // First valid requester at or after rr_ptr wins, unless the tag FIFO is one
  // short of full (no credit for a same-cycle pop) or reset is asserted.
  always_comb begin
    int idx;
    grant_ok  = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_ok && req_valid[idx]) begin
        grant_ok  = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
    if (!rst_n || fifo_full || (fifo_count >= CNT_W'(TAG_DEPTH - 1))) grant_ok = 1'b0;
    if (grant_ok) req_ready[grant_idx] = 1'b1;
  end

  // A result strobe with no outstanding tag is a protocol error, not a pop.
  assign pop  = cvalid_out & ~fifo_empty;
  assign busy = (fifo_count != '0);

  cordic_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_ok),
    .din   (tag_t'(grant_idx)),
    .pop   (pop),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue registers, pointer advance, result routing and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      cx         <= '0;
      cy         <= '0;
      cz         <= '0;
      cmode      <= MODE_ROT;
      cvalid_in  <= 1'b0;
      resp_valid <= '0;
      resp_cos   <= '0;
      resp_sin   <= '0;
      resp_tan   <= '0;
      err        <= 1'b0;
    end else begin
      cvalid_in <= grant_ok;
      if (grant_ok) begin
        cx     <= x_arr[grant_idx];
        cy     <= y_arr[grant_idx];
        cz     <= z_arr[grant_idx];
        cmode  <= req_mode[grant_idx];
        rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
      end
      resp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (pop) begin
        resp_cos <= ccos;
        resp_sin <= csin;
        resp_tan <= ctan;
      end
      if (cvalid_out && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: stub in-order core, queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_cordic_rr_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NS = 13;
  localparam int TD = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic [N*W-1:0] req_z = '0;
  logic [N-1:0]   req_mode = '0;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_cos, resp_sin, resp_tan;
  logic [W-1:0]   cx, cy, cz;
  logic           cmode, cvalid_in;
  logic [W-1:0]   ccos, csin, ctan;
  logic           cvalid_out;
  logic           busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_rr_sched #(.NUM_REQ(N), .WIDTH(W), .NUM_STAGES(NS), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_mode(req_mode),
    .resp_valid(resp_valid), .resp_cos(resp_cos), .resp_sin(resp_sin), .resp_tan(resp_tan),
    .cx(cx), .cy(cy), .cz(cz), .cmode(cmode), .cvalid_in(cvalid_in),
    .ccos(ccos), .csin(csin), .ctan(ctan), .cvalid_out(cvalid_out),
    .busy(busy), .err(err)
  );

  // Stub core: NS-deep in-order delay with a simple data transform. It has no
  // reset so in-flight results survive a scheduler reset.
  logic         core_en = 1'b1;
  logic         inject  = 1'b0;
  logic         pv [NS] = '{default: 1'b0};
  logic [W-1:0] pc [NS] = '{default: '0};
  logic [W-1:0] ps [NS] = '{default: '0};
  logic [W-1:0] pt [NS] = '{default: '0};

  always @(posedge clk) begin
    pv[0] <= cvalid_in & core_en;
    pc[0] <= cx + 32'd1;
    ps[0] <= cy ^ 32'h5A5A_5A5A;
    pt[0] <= cz - 32'd7;
    for (int i = 1; i < NS; i++) begin
      pv[i] <= pv[i-1];
      pc[i] <= pc[i-1];
      ps[i] <= ps[i-1];
      pt[i] <= pt[i-1];
    end
  end

  assign cvalid_out = inject | pv[NS-1];
  assign ccos = inject ? 32'h1111_0001 : pc[NS-1];
  assign csin = inject ? 32'h2222_0002 : ps[NS-1];
  assign ctan = inject ? 32'h3333_0003 : pt[NS-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: owner queue, rotating priority, expected registered outputs.
  int           q[$];
  int           mptr = 0;
  logic [N-1:0] e_ready;
  logic         e_cvin = 1'b0, e_cmode = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_cx = '0, e_cy = '0, e_cz = '0;
  logic [W-1:0] e_rc = '0, e_rs = '0, e_rt = '0;
  logic [N-1:0] e_rv = '0;

  initial begin
    forever begin
      int g;
      int t;
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mptr = 0; e_cvin = 0; e_cmode = 0; e_err = 0;
        e_cx = '0; e_cy = '0; e_cz = '0; e_rc = '0; e_rs = '0; e_rt = '0; e_rv = '0;
        chk("rst_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_cvalid_in", cvalid_in, 0);
        chk("rst_cx", cx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        continue;
      end
      g = -1;
      if (q.size() < TD - 1)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      chk("m_ready", req_ready, e_ready);
      chk("m_cvalid_in", cvalid_in, e_cvin);
      chk("m_cx", cx, e_cx);
      chk("m_cy", cy, e_cy);
      chk("m_cz", cz, e_cz);
      chk("m_cmode", cmode, e_cmode);
      chk("m_resp_valid", resp_valid, e_rv);
      chk("m_resp_cos", resp_cos, e_rc);
      chk("m_resp_sin", resp_sin, e_rs);
      chk("m_resp_tan", resp_tan, e_rt);
      chk("m_busy", busy, q.size() != 0);
      chk("m_err", err, e_err);
      // Next-edge effects: pop against the pre-push queue, then push.
      e_rv = '0;
      if (cvalid_out) begin
        if (q.size() == 0) e_err = 1'b1;
        else begin
          t = q.pop_front();
          e_rv = N'(1) << t;
          e_rc = ccos; e_rs = csin; e_rt = ctan;
          $display("resp  req=%0d cos=%h sin=%h tan=%h", t, ccos, csin, ctan);
        end
      end
      e_cvin = (g >= 0);
      if (g >= 0) begin
        e_cx = req_x[g*W +: W];
        e_cy = req_y[g*W +: W];
        e_cz = req_z[g*W +: W];
        e_cmode = req_mode[g];
        q.push_back(g);
        mptr = (g + 1) % N;
        $display("issue req=%0d x=%h y=%h z=%h mode=%0d", g, e_cx, e_cy, e_cz, e_cmode);
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_valid = '0;
    inject = 1'b0;
    core_en = 1'b1;
    tick(n);
    rst_n = 1'b1;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int n;
    int cnt;
    int grants;
    int rsp[$];

    // Single request through the full pipeline.
    do_reset(20);
    req_x[2*W +: W] = 32'h26DD_3B6A;
    req_y[2*W +: W] = 32'h0;
    req_z[2*W +: W] = 32'h2000_0000;
    req_mode[2] = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_cvalid_in", cvalid_in, 1);
    chk("t1_cx", cx, 32'h26DD_3B6A);
    chk("t1_cz", cz, 32'h2000_0000);
    n = 1;
    while (resp_valid == '0 && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("t1_latency", n, 15);
    chk("t1_resp_valid", resp_valid, 4'b0100);
    chk("t1_resp_cos", resp_cos, 32'h26DD_3B6B);
    chk("t1_resp_sin", resp_sin, 32'h5A5A_5A5A);
    chk("t1_resp_tan", resp_tan, 32'h1FFF_FFF9);

    // Full contention from reset: strict rotation, responses in issue order.
    do_reset(20);
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = 32'h1000_0000 + i;
      req_y[i*W +: W] = 32'(i * 3);
      req_z[i*W +: W] = -32'(i);
      req_mode[i] = 1'(i % 2);
    end
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, N'(1) << (i % N));
      tick();
    end
    req_valid = '0;
    rsp.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid != '0) rsp.push_back(oh2i(resp_valid));
      tick();
    end
    chk("t2_resp_count", rsp.size(), 12);
    for (int i = 0; i < rsp.size(); i++) chk("t2_resp_order", rsp[i], i % N);

    // FIFO full with a stalled core: TD-1 grants, then held until a pop.
    do_reset(20);
    core_en = 1'b0;
    req_valid = '1;
    grants = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (req_ready != '0) grants++;
      tick();
    end
    chk("t3_grants", grants, TD - 1);
    inject = 1'b1;
    @(negedge clk);
    chk("t3_no_bypass", req_ready, '0);
    tick();
    inject = 1'b0;
    @(negedge clk);
    chk("t3_first_resp", resp_valid, 4'b0001);
    chk("t3_regrant", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    chk("t3_full_again", req_ready, '0);
    req_valid = '0;

    // Steady stream: push and pop every cycle at constant occupancy.
    do_reset(20);
    req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c >= 20) begin
        chk("t4_count", dut.fifo_count, NS + 1);
        chk("t4_ready_any", |req_ready, 1);
      end
      tick();
    end
    req_valid = '0;
    tick(20);

    // Spurious result strobe with nothing issued.
    do_reset(20);
    tick();
    inject = 1'b1;
    @(negedge clk);
    chk("t5_err_before", err, 0);
    tick();
    inject = 1'b0;
    @(negedge clk);
    chk("t5_err", err, 1);
    chk("t5_resp_valid", resp_valid, '0);
    tick(3);
    @(negedge clk);
    chk("t5_err_sticky", err, 1);

    // Reset while five operations are in flight.
    do_reset(20);
    req_valid = '1;
    tick(5);
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("t6_rst_ready", req_ready, '0);
    chk("t6_rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_first_grant", req_ready, 4'b0001);
    chk("t6_busy_clear", busy, 0);
    tick();
    req_valid = '0;
    tick(30);
    @(negedge clk);
    chk("t6_stale_err", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
